// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 sprite draw engine.
package chip8_pkg;

  localparam logic [11:0] FB_BASE      = 12'hF00;
  localparam int          SCREEN_W     = 64;
  localparam int          SCREEN_H     = 32;
  localparam int          FB_ROW_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE,
    SPR_RD,
    FBL_RD,
    FBL_WR,
    FBR_RD,
    FBR_WR,
    NEXT
  } state_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [3:0]  n;
    logic [5:0]  xc;
    logic [4:0]  yc;
  } draw_req_t;

  // Framebuffer byte holding pixel row yr, byte column col.
  function automatic logic [11:0] fb_addr(input logic [11:0] base, input logic [4:0] yr,
                                          input logic [2:0] col);
    return base + {4'b0, yr, 3'b000} + {9'b0, col};
  endfunction

endpackage

// File: rtl/chip8_sprite_ppu_if.sv
// RAM port bundle between the sprite engine (master) and chip8_ram (slave).
interface chip8_sprite_ppu_if;
  logic [11:0] mem_read_address;
  logic [7:0]  mem_read_data;
  logic        mem_read_enable;
  logic [11:0] mem_write_address;
  logic [7:0]  mem_write_data;
  logic        mem_write_enable;

  modport master (
    output mem_read_address, mem_read_enable,
    output mem_write_address, mem_write_data, mem_write_enable,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_address, mem_read_enable,
    input  mem_write_address, mem_write_data, mem_write_enable,
    output mem_read_data
  );
endinterface

// File: rtl/chip8_sprite_ppu.sv
// DXYN sprite engine: reads N sprite bytes at I and XORs them into the 64x32 framebuffer in RAM.
module chip8_sprite_ppu
  import chip8_pkg::*;
#(
  parameter logic [11:0] FB_BASE = chip8_pkg::FB_BASE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       draw_i,
  input  logic [11:0]                address_i,
  input  logic [3:0]                 sprite_height_i,
  input  logic [7:0]                 x_i,
  input  logic [7:0]                 y_i,
  output logic                       busy_o,
  output logic                       collision_o,
  chip8_sprite_ppu_if.master         mem
);

  state_t      state_q;
  draw_req_t   req_q;
  logic [3:0]  r_q;
  logic [7:0]  s_q;
  logic        busy_q, coll_q;

  logic [4:0]  yr;
  logic [2:0]  lcol, rcol;
  logic [15:0] span;
  logic [7:0]  ml, mr;

  // Sprite byte shifted across the two framebuffer bytes it can straddle.
  assign span = {s_q, 8'h00} >> req_q.xc[2:0];
  assign ml   = span[15:8];
  assign mr   = span[7:0];
  assign yr   = req_q.yc + {1'b0, r_q};
  assign lcol = req_q.xc[5:3];
  assign rcol = lcol + 3'd1;

  assign busy_o      = busy_q;
  assign collision_o = coll_q;

  always_comb begin
    mem.mem_read_address  = '0;
    mem.mem_read_enable   = 1'b0;
    mem.mem_write_address = '0;
    mem.mem_write_data    = '0;
    mem.mem_write_enable  = 1'b0;
    case (state_q)
      SPR_RD: begin
        mem.mem_read_address = req_q.addr + {8'b0, r_q};
        mem.mem_read_enable  = 1'b1;
      end
      FBL_RD: begin
        mem.mem_read_address = fb_addr(FB_BASE, yr, lcol);
        mem.mem_read_enable  = 1'b1;
      end
      FBL_WR: begin
        mem.mem_write_address = fb_addr(FB_BASE, yr, lcol);
        mem.mem_write_data    = mem.mem_read_data ^ ml;
        mem.mem_write_enable  = 1'b1;
      end
      FBR_RD: begin
        mem.mem_read_address = fb_addr(FB_BASE, yr, rcol);
        mem.mem_read_enable  = 1'b1;
      end
      FBR_WR: begin
        mem.mem_write_address = fb_addr(FB_BASE, yr, rcol);
        mem.mem_write_data    = mem.mem_read_data ^ mr;
        mem.mem_write_enable  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      coll_q  <= 1'b0;
      req_q   <= '0;
      r_q     <= '0;
      s_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (draw_i) begin
          coll_q <= 1'b0;
          if (sprite_height_i != 4'd0) begin
            req_q   <= '{addr: address_i, n: sprite_height_i, xc: x_i[5:0], yc: y_i[4:0]};
            r_q     <= '0;
            state_q <= SPR_RD;
            busy_q  <= 1'b1;
          end
        end
        SPR_RD: state_q <= FBL_RD;
        FBL_RD: begin
          s_q     <= mem.mem_read_data;
          state_q <= FBL_WR;
        end
        FBL_WR: begin
          coll_q  <= coll_q | (|(mem.mem_read_data & ml));
          state_q <= (req_q.xc[2:0] == 3'd0) ? NEXT : FBR_RD;
        end
        FBR_RD: state_q <= FBR_WR;
        FBR_WR: begin
          coll_q  <= coll_q | (|(mem.mem_read_data & mr));
          state_q <= NEXT;
        end
        NEXT: begin
          r_q <= r_q + 4'd1;
          if (r_q + 4'd1 == req_q.n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= SPR_RD;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_sprite_ppu.sv
// Bench for chip8_sprite_ppu: RAM model, pixel-level reference framebuffer, directed and random draws.
module tb_chip8_sprite_ppu;

  logic        clk = 1'b0;
  logic        reset;
  logic        draw;
  logic [11:0] address;
  logic [3:0]  sprite_height;
  logic [7:0]  x, y;
  logic        busy, collision;

  chip8_sprite_ppu_if mem_bus();

  chip8_sprite_ppu dut (
    .clk             (clk),
    .reset           (reset),
    .draw_i          (draw),
    .address_i       (address),
    .sprite_height_i (sprite_height),
    .x_i             (x),
    .y_i             (y),
    .busy_o          (busy),
    .collision_o     (collision),
    .mem             (mem_bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:4095];
  logic [7:0] q;
  assign mem_bus.mem_read_data = q;

  always @(posedge clk) begin
    if (mem_bus.mem_write_enable) ram[mem_bus.mem_write_address] <= mem_bus.mem_write_data;
    q <= ram[mem_bus.mem_read_address];
  end

  int clash = 0;
  always @(negedge clk) if (mem_bus.mem_read_enable && mem_bus.mem_write_enable) clash++;

  int errors = 0;
  int checks = 0;

  bit pix [32][64];
  bit exp_coll;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel-level DXYN: every lit sprite pixel toggles one screen pixel, wrapping both axes.
  task automatic model(input logic [11:0] i_addr, input int n, input int xv, input int yv,
                       input int rows);
    logic [7:0] spr [16];
    for (int r = 0; r < n; r++) spr[r] = ram[(int'(i_addr) + r) % 4096];
    exp_coll = 1'b0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < 8; c++)
        if (spr[r][7-c]) begin
          int py, px;
          py = ((yv % 32) + r) % 32;
          px = ((xv % 64) + c) % 64;
          if (pix[py][px]) exp_coll = 1'b1;
          pix[py][px] = ~pix[py][px];
        end
  endtask

  function automatic logic [7:0] mbyte(input int row, input int col);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[7-b] = pix[row][col*8+b];
    return v;
  endfunction

  task automatic check_fb(input string tag);
    int bad = 0;
    for (int a = 0; a < 256; a++)
      if (ram[12'hF00 + a] !== mbyte(a / 8, a % 8)) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic clear_fb();
    for (int a = 0; a < 256; a++) ram[12'hF00 + a] = 8'h00;
    for (int r = 0; r < 32; r++) for (int c = 0; c < 64; c++) pix[r][c] = 1'b0;
  endtask

  int  cyc, wcnt, acc;
  bit  f01, tmo;

  task automatic do_draw(input logic [11:0] i_addr, input logic [3:0] n, input logic [7:0] xv,
                         input logic [7:0] yv, input bit pulse, input int abort_at);
    @(negedge clk);
    address = i_addr; sprite_height = n; x = xv; y = yv; draw = 1'b1;
    cyc = 0; wcnt = 0; acc = 0; f01 = 1'b0; tmo = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mem_bus.mem_read_enable || mem_bus.mem_write_enable) acc++;
      if (!busy) begin
        draw = 1'b0; tmo = 1'b0;
        break;
      end
      cyc++;
      if (mem_bus.mem_write_enable) begin
        wcnt++;
        if (mem_bus.mem_write_address == 12'hF01) f01 = 1'b1;
      end
      draw = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      if (abort_at != 0 && cyc == abort_at) begin
        draw = 1'b0; reset = 1'b1; tmo = 1'b0;
        break;
      end
    end
    if (tmo) chk("draw_timeout", 1, 0);
  endtask

  task automatic full_draw(input string tag, input logic [11:0] i_addr, input logic [3:0] n,
                           input logic [7:0] xv, input logic [7:0] yv, input bit pulse);
    int per;
    per = (xv[2:0] == 3'd0) ? 4 : 6;
    model(i_addr, n, xv, yv, n);
    do_draw(i_addr, n, xv, yv, pulse, 0);
    check_fb({tag, "_fb"});
    chk({tag, "_coll"}, collision, exp_coll);
    chk({tag, "_cycles"}, cyc, n * per);
    chk({tag, "_writes"}, wcnt, n * ((per == 4) ? 1 : 2));
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
    clear_fb();
    reset = 1'b1; draw = 1'b0; address = '0; sprite_height = '0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_coll", collision, 0);
    chk("rst_en", {mem_bus.mem_read_enable, mem_bus.mem_write_enable}, 0);
    chk("rst_addr", {mem_bus.mem_read_address, mem_bus.mem_write_address,
                     mem_bus.mem_write_data}, 0);
    reset = 1'b0;

    ram[12'h22A] = 8'hFF;
    full_draw("d1", 12'h22A, 4'd1, 8'd12, 8'd8, 1'b0);
    chk("d1_f41", ram[12'hF41], 8'h0F);
    chk("d1_f42", ram[12'hF42], 8'hF0);

    full_draw("d2", 12'h22A, 4'd1, 8'd12, 8'd8, 1'b0);
    chk("d2_f41", ram[12'hF41], 8'h00);
    chk("d2_f42", ram[12'hF42], 8'h00);
    chk("d2_coll1", collision, 1);

    ram[12'h300] = 8'hFF;
    full_draw("wrap", 12'h300, 4'd1, 8'd62, 8'd31, 1'b0);
    chk("wrap_fff", ram[12'hFFF], 8'h03);
    chk("wrap_ff8", ram[12'hFF8], 8'hFC);
    full_draw("mod", 12'h300, 4'd1, 8'd70, 8'd40, 1'b0);
    chk("mod_f40", ram[12'hF40], 8'h03);
    chk("mod_f41", ram[12'hF41], 8'hFC);

    ram[12'h400] = 8'h81; ram[12'h401] = 8'h42; ram[12'h402] = 8'h24;
    full_draw("al", 12'h400, 4'd3, 8'd0, 8'd0, 1'b0);
    chk("al_f00", ram[12'hF00], 8'h81);
    chk("al_f08", ram[12'hF08], 8'h42);
    chk("al_f10", ram[12'hF10], 8'h24);
    chk("al_cycles12", cyc, 12);
    chk("al_no_f01", f01, 0);

    for (int k = 1; k < 15; k++) ram[12'h22A + k] = 8'($urandom);
    full_draw("n15", 12'h22A, 4'd15, 8'd12, 8'd8, 1'b1);
    chk("n15_cycles90", cyc, 90);
    chk("n15_writes30", wcnt, 30);
    chk("n15_busy_low", busy, 0);

    // Abort in row 2: rows 0 and 1 are already in the framebuffer, row 2 never written.
    model(12'h22A, 15, 12, 8, 2);
    do_draw(12'h22A, 4'd15, 8'd12, 8'd8, 1'b0, 14);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_coll", collision, 0);
    chk("abort_en", {mem_bus.mem_read_enable, mem_bus.mem_write_enable}, 0);
    check_fb("abort_fb");

    for (int k = 0; k < 4; k++) ram[12'h500 + k] = 8'($urandom);
    full_draw("clean", 12'h500, 4'd4, 8'd33, 8'd17, 1'b0);
    full_draw("again", 12'h500, 4'd4, 8'd33, 8'd17, 1'b0);
    do_draw(12'h500, 4'd0, 8'd5, 8'd5, 1'b0, 0);
    chk("n0_coll", collision, 0);
    chk("n0_access", acc, 0);
    chk("n0_cycles", cyc, 0);
    check_fb("n0_fb");

    ram[12'h000] = 8'hA5;
    full_draw("iwrap", 12'hFFF, 4'd2, 8'd20, 8'd0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      logic [11:0] ia;
      logic [3:0]  nn;
      ia = 12'($urandom_range(12'h200, 12'hEF0));
      nn = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) ram[ia + 12'(k)] = 8'($urandom);
      full_draw($sformatf("rnd%0d", t), ia, nn, 8'($urandom), 8'($urandom), 1'(t % 2));
    end

    chk("rw_clash", clash, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chip8_sprite_ppu.md
Name: chip8_sprite_ppu

Overview:
- CHIP-8 sprite draw engine; executes DXYN on behalf of the CPU.
- Reads N sprite bytes from RAM at I and XORs them into a 64x32 1-bpp framebuffer stored in the same RAM at 0xF00–0xFFF.
- Reports pixel collision (VF).
- Connects to chip8_ram: synchronous, 1-cycle read latency, separate read and write ports.

Parameters:
- FB_BASE, 12'hF00, framebuffer base address. 8 bytes per row, 32 rows; byte = FB_BASE + row*8 + col/8; MSB = leftmost pixel.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
draw  in  1  start request, sampled only when idle
address  in  12  sprite base I
sprite_height  in  4  N rows, 0..15
x  in  8  Vx; column taken mod 64
y  in  8  Vy; row taken mod 32
busy  out  1  high while a draw is in progress
collision  out  1  set if any lit pixel was cleared during the last draw
mem_read_address  out  12  RAM read address
mem_read_data  in  8  RAM q; valid the cycle after the address is driven
mem_read_enable  out  1  high in read-issue states
mem_write_address  out  12  RAM write address
mem_write_data  out  8  RAM write data
mem_write_enable  out  1  RAM write strobe, one cycle per write

Behaviour:
- Reset values: state IDLE; busy=0, collision=0; all enables 0; addresses and write data 0. Reset mid-draw aborts immediately. Framebuffer bytes already written stay as written.
- busy = (state != IDLE), registered.
- IDLE + draw=1 with N>0:
  - Latch I, N, xc = x[5:0], yc = y[4:0]. Set row r=0, clear collision.
  - Next state SPR_RD.
- IDLE + draw=1 with N=0: clear collision, stay IDLE, no memory access.
- draw is ignored while busy.
- States per row r:
  - SPR_RD: read addr = (I + r) mod 4096; read_en=1.
  - FBL_RD: latch sprite byte s = mem_read_data. Read addr = FB_BASE + ((yc+r)&31)*8 + xc[5:3]; read_en=1.
  - FBL_WR: m = s >> xc[2:0]. Write (old ^ m) to the same address. collision |= |(old & m). Next: NEXT if xc[2:0]==0, else FBR_RD.
  - FBR_RD: read addr = same row, byte (xc[5:3]+1)&7 (horizontal wrap); read_en=1.
  - FBR_WR: m = (s << (8 - xc[2:0]))[7:0]. Write old ^ m; collision |= |(old & m).
  - NEXT: r++. If r==N go to IDLE, else SPR_RD.
- Timing:
  - Busy cycles = 4 per byte-aligned row, 6 per unaligned row.
  - Example: x=12, N=15 gives 90 busy cycles.
- Vertical wrap uses row (yc+r) mod 32. Sprite address wraps at 12 bits.
- collision holds its value until the next accepted draw or reset.
- Never read and write in the same cycle.
- The write port is driven only in *_WR states; the read port only in *_RD states.

Decomposition:
- Shared package chip8_pkg:
  - state enum
  - FB_BASE, SCREEN_W=64, SCREEN_H=32, FB_ROW_BYTES=8
- No sub-module needed. chip8_ram stays a separate block: 4096x8, registered q, write when we.

Test Plan:
- Cleared framebuffer, RAM[0x22A]=0xFF, x=12, y=8, N=1, I=0x22A → write 0x0F to 0xF41 and 0xF0 to 0xF42; collision=0; busy high 6 cycles.
- Repeat the same draw → 0xF41 and 0xF42 return to 0x00; collision=1.
- Wrap: x=62, y=31, sprite 0xFF, N=1 → 0xFFF=0x03, 0xFF8=0xFC. Then x=70, y=40 draws at column 6, row 8.
- Aligned: x=0, y=0, N=3, sprite bytes 0x81, 0x42, 0x24 → 0xF00=0x81, 0xF08=0x42, 0xF10=0x24; busy exactly 12 cycles; no writes to 0xF01.
- x=12, y=8, N=15, I=0x22A → busy 90 cycles; 30 writes; busy falls to 0; draw pulses while busy are ignored.
- Assert reset mid-draw (row 2) → next cycle busy=0, collision=0, enables 0. A subsequent draw starts cleanly. N=0 draw → no memory access, collision=0.
